// File: rtl/tenkey_conditioner.sv
// tenkey_conditioner: synchronises, debounces and multi-key-filters ten keypad lines
// into a single-cycle one-hot key code for the lock controller.
module tenkey_conditioner #(
    parameter int DEBOUNCE = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sw_raw,
    output logic [9:0] tenkey,
    output logic       key_valid,
    output logic       multi_err,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, DEB, WAIT_REL} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       s1_q, sw_s_q, cand_q, cand_d, tenkey_q, tenkey_d;
    logic             key_valid_q, key_valid_d, multi_err_q, multi_err_d, busy_q, busy_d;
    logic             any, onehot, multi;

    assign any    = |sw_s_q;
    assign onehot = any && ((sw_s_q & (sw_s_q - 10'd1)) == 10'd0);
    assign multi  = any && !onehot;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        tenkey_d    = '0;
        key_valid_d = 1'b0;
        multi_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (onehot) begin
                    cand_d  = sw_s_q;
                    cnt_d   = ONE;
                    state_d = DEB;
                end else if (multi) begin
                    multi_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT_REL;
                end
            end
            DEB: begin
                if (multi) begin
                    multi_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT_REL;
                end else if (!any) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sw_s_q == cand_q) begin
                    if (cnt_q == LAST) begin
                        tenkey_d    = cand_q;
                        key_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = WAIT_REL;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else begin
                    cand_d = sw_s_q;
                    cnt_d  = ONE;
                end
            end
            WAIT_REL: begin
                // any activity, including extra keys, restarts the release count silently
                if (any) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            sw_s_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            tenkey_q    <= '0;
            key_valid_q <= 1'b0;
            multi_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            s1_q        <= sw_raw;
            sw_s_q      <= s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            tenkey_q    <= tenkey_d;
            key_valid_q <= key_valid_d;
            multi_err_q <= multi_err_d;
            busy_q      <= busy_d;
        end
    end

    assign tenkey    = tenkey_q;
    assign key_valid = key_valid_q;
    assign multi_err = multi_err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_tenkey_conditioner.sv
// tb_tenkey_conditioner: directed stimulus with a pulse scoreboard (expected code and cycle)
// drained by an independent output monitor.
module tb_tenkey_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sw_raw = '0;
    logic [9:0] tenkey;
    logic       key_valid, multi_err, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic       multi;
        logic [9:0] code;
        int         at;
    } exp_t;
    exp_t sb[$];

    tenkey_conditioner #(.DEBOUNCE(4), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
        .tenkey(tenkey), .key_valid(key_valid), .multi_err(multi_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: every pulse must match the head of the scoreboard, including its cycle
    always @(negedge clk) begin
        if (rst_n) begin
            check("kv_vs_tenkey", int'(key_valid), int'(tenkey != 10'd0));
            if (key_valid || multi_err || tenkey != 10'd0) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {multi_err, key_valid, tenkey}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_kind", {multi_err, key_valid, tenkey},
                          e.multi ? {2'b10, 10'd0} : {2'b01, e.code});
                    check("pulse_cycle", cyc, e.at);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [9:0] v);
        sw_raw = v;
    endtask

    task automatic expect_key(input logic [9:0] v, input int at);
        sb.push_back('{multi: 1'b0, code: v, at: at});
    endtask

    task automatic at_negedge(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int n0;
        tick(3);
        check("rst_tenkey", int'(tenkey), 0);
        check("rst_kv", int'(key_valid), 0);
        check("rst_me", int'(multi_err), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick(3);

        // 1: clean press, pulse after edge 5, busy drops 4 samples after sw_s clears
        n0 = cyc; press(10'h080); expect_key(10'h080, n0 + 6);
        tick(20);
        n0 = cyc; press(10'h000);
        at_negedge(n0 + 5);
        check("t1_busy_held", int'(busy), 1);
        at_negedge(n0 + 6);
        check("t1_busy_drop", int'(busy), 0);
        tick(4);

        // 2: bounce then steady hold
        repeat (3) begin
            press(10'h008); tick(2);
            press(10'h000); tick(2);
        end
        n0 = cyc; press(10'h008); expect_key(10'h008, n0 + 6);
        tick(10); press(10'h000); tick(10);

        // 3: two keys at once, then clean press after release
        n0 = cyc; press(10'h00C);
        sb.push_back('{multi: 1'b1, code: 10'h000, at: n0 + 3});
        tick(8); press(10'h000); tick(8);
        n0 = cyc; press(10'h004); expect_key(10'h004, n0 + 6);
        tick(10); press(10'h000); tick(8);

        // 4: second key added while first is held is ignored
        n0 = cyc; press(10'h001); expect_key(10'h001, n0 + 6);
        tick(7); press(10'h021); tick(10);
        check("t4_busy_while_held", int'(busy), 1);
        press(10'h000); tick(8);

        // 5: key 3 then key 7
        n0 = cyc; press(10'h008); expect_key(10'h008, n0 + 6);
        tick(8); press(10'h000); tick(8);
        check("t5_gap_ge_8", int'((cyc + 6) - (n0 + 6) >= 8), 1);
        n0 = cyc; press(10'h080); expect_key(10'h080, n0 + 6);
        tick(10); press(10'h000); tick(8);

        // 6: reset two cycles into debounce; no pulse until a fresh press
        n0 = cyc; press(10'h080);
        tick(5);
        check("t6_busy_pre_rst", int'(busy), 1);
        rst_n = 1'b0; press(10'h000);
        #1;
        check("t6_async_busy", int'(busy), 0);
        check("t6_async_out", {multi_err, key_valid, tenkey}, 0);
        tick(2); rst_n = 1'b1; tick(10);
        n0 = cyc; press(10'h080); expect_key(10'h080, n0 + 6);
        tick(10); press(10'h000); tick(10);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
